// File: rtl/puf_ctrl_pkg.sv
// ============================================================================
// puf_ctrl_pkg : shared FSM states and sizing helpers for the PUF sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package puf_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RELAX  = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_EMIT   = 3'd4
    } state_e;

    localparam int c_vote_count = 3;
    localparam int c_vote_w     = 2;

    function automatic int cnt_width(input int run_cycles, input int relax_cycles);
        int m;
        m = (run_cycles > relax_cycles) ? run_cycles : relax_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/puf_resp_packer.sv
// ============================================================================
// puf_resp_packer : LSB-first response packer holding a word for valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

module puf_resp_packer #(
    parameter int WORD_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic                 bit_i,
    input  logic                 emit_i,
    input  logic                 last_i,
    input  logic                 ready_i,
    output logic [WORD_BITS-1:0] resp_data_o,
    output logic                 resp_valid_o,
    output logic                 resp_last_o,
    output logic                 full_next_o
);

    logic [WORD_BITS-1:0] data_q, data_d;
    logic [WORD_BITS-1:0] pos_q, pos_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;

    // pos_q is a one-hot fill index; unwritten positions stay zero after clear
    always_comb begin
        data_d  = data_q;
        pos_d   = pos_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (clear_i) begin
            data_d  = '0;
            pos_d   = WORD_BITS'(1);
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            if (push_i) begin
                if (bit_i) begin
                    data_d = data_q | pos_q;
                end
                pos_d = pos_q << 1;
            end
            if (emit_i) begin
                valid_d = 1'b1;
                last_d  = last_i;
            end
            if (valid_q && ready_i) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            pos_q   <= WORD_BITS'(1);
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign resp_data_o  = data_q;
    assign resp_valid_o = valid_q;
    assign resp_last_o  = last_q;
    assign full_next_o  = pos_q[WORD_BITS-1];

endmodule

`default_nettype wire

// File: rtl/puf_challenge_sequencer.sv
// ============================================================================
// puf_challenge_sequencer : sweeps DelayPUF challenges and packs the responses
// Option macro PUF_MAJORITY_VOTE_EN : 2-of-3 vote per challenge.   Rev 1.0
// ============================================================================
`default_nettype none

module puf_challenge_sequencer
    import puf_ctrl_pkg::*;
#(
    parameter int PUF_LENGTH   = 8,
    parameter int WORD_BITS    = 32,
    parameter int RUN_CYCLES   = 10,
    parameter int RELAX_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PUF_LENGTH-1:0] first_chal,
    input  logic [PUF_LENGTH-1:0] last_chal,
    output logic [PUF_LENGTH-1:0] puf_challenge,
    output logic                  puf_run,
    input  logic                  puf_result,
    output logic [WORD_BITS-1:0]  resp_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_last,
    output logic                  busy,
    output logic                  done
);

    localparam int                c_cnt_w      = cnt_width(RUN_CYCLES, RELAX_CYCLES);
    localparam logic [c_cnt_w-1:0] c_run_last   = c_cnt_w'(RUN_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_relax_last = c_cnt_w'(RELAX_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [c_cnt_w-1:0]      cnt_q, cnt_d;
    logic [PUF_LENGTH-1:0]   chal_q, chal_d;
    logic [PUF_LENGTH-1:0]   last_q, last_d;
    logic                    done_q, done_d;

    logic w_pk_clear, w_pk_push, w_pk_emit, w_pk_last, w_full_next;
    logic w_final_eval, w_sample_bit, w_is_last;

    assign w_is_last = (chal_q == last_q);

`ifdef PUF_MAJORITY_VOTE_EN
    logic [c_vote_w-1:0] vote_q;
    logic [c_vote_w-1:0] ones_q;
    logic [c_vote_w-1:0] w_ones_sum;

    assign w_ones_sum   = ones_q + c_vote_w'(puf_result);
    assign w_final_eval = (vote_q == c_vote_w'(c_vote_count - 1));
    assign w_sample_bit = (w_ones_sum >= c_vote_w'(2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vote_q <= '0;
            ones_q <= '0;
        end else if (abort || state_q == ST_IDLE) begin
            vote_q <= '0;
            ones_q <= '0;
        end else if (state_q == ST_SAMPLE) begin
            if (w_final_eval) begin
                vote_q <= '0;
                ones_q <= '0;
            end else begin
                vote_q <= vote_q + c_vote_w'(1);
                ones_q <= w_ones_sum;
            end
        end
    end
`else
    assign w_final_eval = 1'b1;
    assign w_sample_bit = puf_result;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        chal_d     = chal_q;
        last_d     = last_q;
        done_d     = 1'b0;
        w_pk_clear = 1'b0;
        w_pk_push  = 1'b0;
        w_pk_emit  = 1'b0;
        w_pk_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ARM;
                    chal_d     = first_chal;
                    last_d     = last_chal;
                    cnt_d      = '0;
                    w_pk_clear = 1'b1;
                end
            end
            ST_ARM: begin
                if (cnt_q == c_run_last) begin
                    cnt_d   = '0;
                    state_d = ST_RELAX;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            ST_RELAX: begin
                if (cnt_q == c_relax_last) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            ST_SAMPLE: begin
                state_d = ST_ARM;
                if (w_final_eval) begin
                    w_pk_push = 1'b1;
                    if (w_full_next || w_is_last) begin
                        w_pk_emit = 1'b1;
                        w_pk_last = w_is_last;
                        state_d   = ST_EMIT;
                    end else begin
                        chal_d = chal_q + PUF_LENGTH'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (resp_valid && resp_ready) begin
                    if (resp_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        chal_d     = chal_q + PUF_LENGTH'(1);
                        w_pk_clear = 1'b1;
                        state_d    = ST_ARM;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // abort overrides everything, including a same-cycle start or handshake
        if (abort) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            done_d     = 1'b0;
            w_pk_clear = 1'b1;
            w_pk_push  = 1'b0;
            w_pk_emit  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            chal_q  <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chal_q  <= chal_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    puf_resp_packer #(
        .WORD_BITS (WORD_BITS)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (w_pk_clear),
        .push_i       (w_pk_push),
        .bit_i        (w_sample_bit),
        .emit_i       (w_pk_emit),
        .last_i       (w_pk_last),
        .ready_i      (resp_ready),
        .resp_data_o  (resp_data),
        .resp_valid_o (resp_valid),
        .resp_last_o  (resp_last),
        .full_next_o  (w_full_next)
    );

    assign puf_challenge = chal_q;
    assign puf_run       = (state_q == ST_ARM);
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_puf_challenge_sequencer.sv
// ============================================================================
// tb_puf_challenge_sequencer : self-checking bench with a behavioural PUF map
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_puf_challenge_sequencer;

    localparam int PL    = 8;
    localparam int WB    = 32;
    localparam int RUN   = 10;
    localparam int RELAX = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [PL-1:0] first_chal;
    logic [PL-1:0] last_chal;
    logic [PL-1:0] puf_challenge;
    logic          puf_run;
    logic          puf_result;
    logic [WB-1:0] resp_data;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    puf_challenge_sequencer #(
        .PUF_LENGTH   (PL),
        .WORD_BITS    (WB),
        .RUN_CYCLES   (RUN),
        .RELAX_CYCLES (RELAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .first_chal    (first_chal),
        .last_chal     (last_chal),
        .puf_challenge (puf_challenge),
        .puf_run       (puf_run),
        .puf_result    (puf_result),
        .resp_data     (resp_data),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_last     (resp_last),
        .busy          (busy),
        .done          (done)
    );

    function automatic logic model_bit(input logic [PL-1:0] c);
        logic [PL-1:0] t;
        t = c * 8'd37 + 8'd11;
        return t[3] ^ t[6];
    endfunction

    assign puf_result = model_bit(puf_challenge);

    typedef struct packed {
        logic [WB-1:0] data;
        logic          last;
    } word_t;

    typedef struct {
        logic [PL-1:0] first;
        logic [PL-1:0] last;
        int            words;
    } tc_t;

    word_t exp_q[$];
    tc_t   tcs[4];

    int            n_cmp    = 0;
    int            n_err    = 0;
    int            word_cnt = 0;
    int            done_cnt = 0;
    int            run_len  = 0;
    logic          chal_moved = 1'b0;
    logic          ign_run    = 1'b0;
    logic [PL-1:0] run_chal   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_expected(input logic [PL-1:0] f, input logic [PL-1:0] l);
        logic [PL-1:0] c;
        logic [WB-1:0] d;
        int            n;
        logic          fin;
        c = f;
        d = '0;
        n = 0;
        forever begin
            d[n] = model_bit(c);
            n++;
            fin = (c == l);
            if (n == WB || fin) begin
                exp_q.push_back('{data: d, last: fin});
                d = '0;
                n = 0;
            end
            if (fin) break;
            c = c + 8'd1;
        end
    endtask

    // Scoreboard and strobe-window monitor, sampled away from the active edge
    always @(negedge clk) begin
        word_t w;
        if (!reset) begin
            if (resp_valid && resp_ready) begin
                word_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", resp_data);
                end else begin
                    w = exp_q.pop_front();
                    check("resp_data", 64'(resp_data), 64'(w.data));
                    check("resp_last", 64'(resp_last), 64'(w.last));
                end
            end
            if (done) done_cnt++;
        end
        if (puf_run) begin
            if (run_len == 0) run_chal = puf_challenge;
            else if (puf_challenge !== run_chal) chal_moved = 1'b1;
            run_len++;
        end else if (run_len > 0) begin
            if (!ign_run) begin
                check("run_len", 64'(run_len), 64'(RUN));
                check("run_chal_stable", 64'(chal_moved), 64'd0);
            end
            run_len    = 0;
            chal_moved = 1'b0;
            ign_run    = 1'b0;
        end
    end

    task automatic pulse_start(input logic [PL-1:0] f, input logic [PL-1:0] l);
        @(posedge clk); #1;
        first_chal = f;
        last_chal  = l;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("run_after_start", 64'(puf_run), 64'd1);
    endtask

    task automatic wait_done(input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic recover();
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        resp_ready = 1'b1;
    endtask

    task automatic run_sweep(input logic [PL-1:0] f, input logic [PL-1:0] l, input int exp_words);
        int w0, d0;
        bit hit;
        w0 = word_cnt;
        d0 = done_cnt;
        push_expected(f, l);
        pulse_start(f, l);
        wait_done(7000, hit);
        check("done_seen", 64'(hit), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("word_count", 64'(word_cnt - w0), 64'(exp_words));
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        if (!hit) recover();
    endtask

    initial begin
        bit            hit;
        int            w0, d0;
        logic [WB-1:0] snap_data;
        logic [PL-1:0] snap_chal;
        logic          data_moved, run_seen, chal_chg, valid_drop;

        tcs[0] = '{8'h00, 8'hFF, 8};
        tcs[1] = '{8'hFE, 8'h01, 1};
        tcs[2] = '{8'h05, 8'h05, 1};
        tcs[3] = '{8'h20, 8'h40, 2};

        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        first_chal = '0;
        last_chal  = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_challenge", 64'(puf_challenge), 64'd0);
        check("rst_run", 64'(puf_run), 64'd0);
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_last", 64'(resp_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", 64'(resp_data), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_sweep(tcs[i].first, tcs[i].last, tcs[i].words);
        end

        // Backpressure: word held for 50 cycles with no evaluation progress
        resp_ready = 1'b0;
        push_expected(8'h40, 8'h47);
        pulse_start(8'h40, 8'h47);
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                hit = 1'b1;
                break;
            end
        end
        check("bp_valid_seen", 64'(hit), 64'd1);
        snap_data  = resp_data;
        snap_chal  = puf_challenge;
        data_moved = 1'b0;
        run_seen   = 1'b0;
        chal_chg   = 1'b0;
        valid_drop = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp_data !== snap_data) data_moved = 1'b1;
            if (puf_run) run_seen = 1'b1;
            if (puf_challenge !== snap_chal) chal_chg = 1'b1;
            if (!resp_valid) valid_drop = 1'b1;
        end
        check("bp_data_stable", 64'(data_moved), 64'd0);
        check("bp_run_low", 64'(run_seen), 64'd0);
        check("bp_chal_frozen", 64'(chal_chg), 64'd0);
        check("bp_valid_held", 64'(valid_drop), 64'd0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        wait_done(20, hit);
        check("bp_done_seen", 64'(hit), 64'd1);
        @(negedge clk);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        if (!hit) recover();

        // Abort during ARM of challenge 0x05
        pulse_start(8'h00, 8'hFF);
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (puf_run && puf_challenge == 8'h05) begin
                hit = 1'b1;
                break;
            end
        end
        check("abort_reach_05", 64'(hit), 64'd1);
        w0 = word_cnt;
        d0 = done_cnt;
        @(posedge clk); #1;
        ign_run = 1'b1;
        abort   = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_run", 64'(puf_run), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(resp_valid), 64'd0);
        repeat (40) @(negedge clk);
        check("abort_no_word", 64'(word_cnt - w0), 64'd0);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // Start and abort together: start is dropped
        @(posedge clk); #1;
        first_chal = 8'h10;
        last_chal  = 8'h12;
        start      = 1'b1;
        abort      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'd0);
        check("start_abort_run", 64'(puf_run), 64'd0);
        repeat (5) @(negedge clk);
        check("start_abort_idle", 64'(busy), 64'd0);

        run_sweep(8'h10, 8'h12, 1);

        // Asynchronous reset mid-sweep
        pulse_start(8'h80, 8'hFF);
        repeat (30) @(negedge clk);
        #2;
        if (puf_run) ign_run = 1'b1;
        reset = 1'b1;
        #1;
        check("arst_run", 64'(puf_run), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_challenge", 64'(puf_challenge), 64'd0);
        check("arst_valid", 64'(resp_valid), 64'd0);
        check("arst_data", 64'(resp_data), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_sweep(8'hF0, 8'h0F, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
